// File: rtl/dvs_pkg.sv
// Shared types for the DVS event SDRAM writer: event word layout, FSM states
// and field widths.
package dvs_pkg;

  localparam int X_W    = 8;
  localparam int Y_W    = 8;
  localparam int TS_W   = 15;
  localparam int EVT_W  = 32;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 25;

  // Low word is {y, x}, high word is {pol, ts}.
  typedef struct packed {
    logic            pol;
    logic [TS_W-1:0] ts;
    logic [Y_W-1:0]  y;
    logic [X_W-1:0]  x;
  } dvs_evt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR_LO = 2'd1,
    ST_WR_HI = 2'd2
  } wr_state_e;

endpackage

// File: rtl/dvs_event_fifo.sv
// Synchronous show-ahead FIFO for packed event words, with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dvs_event_fifo #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Full is judged before any same-cycle pop, so a push into a full FIFO is
  // rejected even when a pop frees a slot on that edge.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/dvs_event_sdram_writer.sv
// Avalon-MM write master: buffers DVS events and writes each as two 16-bit
// words into a circular SDRAM region, exporting pointer and counters.
module dvs_event_sdram_writer
  import dvs_pkg::*;
#(
  parameter logic [24:0] BASE_ADDR = 25'h0,
  parameter int          PTR_W     = 20,
  parameter int          FIFO_AW   = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  input  logic              evt_valid,
  input  logic [7:0]        evt_x,
  input  logic [7:0]        evt_y,
  input  logic              evt_pol,
  input  logic [14:0]       evt_ts,
  output logic [24:0]       avm_address,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic [31:0]       event_count,
  output logic [15:0]       dropped_count,
  output logic              wrapped
);

  wr_state_e          r_state;
  wr_state_e          w_state_next;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [31:0]        r_event_count;
  logic [15:0]        r_dropped;
  logic               r_wrapped;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_write;
  logic [WORD_W-1:0]  r_data;
  logic [1:0]         r_be;
  logic [WORD_W-1:0]  r_hold_hi;

  logic [ADDR_W-1:0]  w_addr_next;
  logic               w_write_next;
  logic [WORD_W-1:0]  w_data_next;
  logic [WORD_W-1:0]  w_hold_hi_next;
  logic               w_pop;
  logic               w_ptr_inc;
  logic               w_evt_done;
  logic               w_capture;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  dvs_evt_t           w_evt_in;
  dvs_evt_t           w_fifo_data;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [PTR_W-1:0] p);
    return BASE_ADDR + ADDR_W'({p, 1'b0});
  endfunction

  assign w_evt_in  = '{pol: evt_pol, ts: evt_ts, y: evt_y, x: evt_x};
  assign w_capture = evt_valid && enable;

  dvs_event_fifo #(
    .AW (FIFO_AW),
    .DW (EVT_W)
  ) u_fifo (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_push  (w_capture),
    .i_data  (w_evt_in),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= ST_IDLE;
    else                r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_pop          = 1'b0;
    w_ptr_inc      = 1'b0;
    w_evt_done     = 1'b0;
    w_write_next   = r_write;
    w_addr_next    = r_addr;
    w_data_next    = r_data;
    w_hold_hi_next = r_hold_hi;
    case (r_state)
      ST_IDLE: begin
        // enable only gates the start of an event; a started event always finishes
        if (!w_fifo_empty && enable) begin
          w_pop          = 1'b1;
          w_hold_hi_next = w_fifo_data[EVT_W-1:WORD_W];
          w_write_next   = 1'b1;
          w_addr_next    = word_addr(r_wr_ptr);
          w_data_next    = w_fifo_data[WORD_W-1:0];
          w_state_next   = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        if (!avm_waitrequest) begin
          w_ptr_inc    = 1'b1;
          w_addr_next  = word_addr(r_wr_ptr + 1'b1);
          w_data_next  = r_hold_hi;
          w_state_next = ST_WR_HI;
        end
      end
      ST_WR_HI: begin
        if (!avm_waitrequest) begin
          w_ptr_inc    = 1'b1;
          w_evt_done   = 1'b1;
          w_write_next = 1'b0;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_wr_ptr      <= '0;
      r_event_count <= '0;
      r_dropped     <= '0;
      r_wrapped     <= 1'b0;
      r_addr        <= '0;
      r_write       <= 1'b0;
      r_data        <= '0;
      r_be          <= '0;
      r_hold_hi     <= '0;
    end else begin
      r_addr    <= w_addr_next;
      r_write   <= w_write_next;
      r_data    <= w_data_next;
      r_be      <= {2{w_write_next}};
      r_hold_hi <= w_hold_hi_next;
      if (w_ptr_inc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_wr_ptr == {PTR_W{1'b1}}) r_wrapped <= 1'b1;
      end
      if (w_evt_done) r_event_count <= r_event_count + 32'd1;
      if (w_capture && w_fifo_full && (r_dropped != 16'hFFFF)) begin
        r_dropped <= r_dropped + 16'd1;
      end
    end
  end

  assign avm_address    = r_addr;
  assign avm_write      = r_write;
  assign avm_writedata  = r_data;
  assign avm_byteenable = r_be;
  assign wr_ptr         = r_wr_ptr;
  assign event_count    = r_event_count;
  assign dropped_count  = r_dropped;
  assign wrapped        = r_wrapped;

endmodule

// File: doc/dvs_event_sdram_writer.md
# dvs_event_sdram_writer

Avalon-MM write master that takes timestamped DVS address-events from the sensor front end and stores them in the SDRAM behind the system's SDRAM controller. Events are buffered in a small FIFO, split into two 16-bit words, and written into a circular region of SDRAM. Pointer and counters are exported so the Nios II software can drain the buffer. The block sits in the Qsys system as a master on the SDRAM controller's Avalon-MM slave port.

## Interface
Parameters:
- BASE_ADDR, 0: byte address of the circular region in SDRAM; must be 4-byte aligned.
- PTR_W, 20: circular region holds 2^PTR_W 16-bit words.
- FIFO_AW, 4: event FIFO depth is 2^FIFO_AW entries.

Ports:
- clk_clk  in  1  system clock; clocks all logic.
- reset_reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable from the software control register.
- evt_valid  in  1  one-cycle strobe: an event is present.
- evt_x  in  8  event column.
- evt_y  in  8  event row.
- evt_pol  in  1  event polarity.
- evt_ts  in  15  event timestamp.
- avm_address  out  25  byte address.
- avm_write  out  1  write request.
- avm_writedata  out  16  write data.
- avm_byteenable  out  2  always 2'b11 while avm_write is high.
- avm_waitrequest  in  1  slave stall.
- wr_ptr  out  PTR_W  index of the next 16-bit word to be written.
- event_count  out  32  events fully written; wraps at 2^32.
- dropped_count  out  16  events lost to a full FIFO; saturates at 16'hFFFF.
- wrapped  out  1  sticky flag; set the first time wr_ptr wraps to 0.

## Operation
- **Event word format:** {evt_pol, evt_ts[14:0], evt_y, evt_x}, 32 bits.
- **Capture:**
  - evt_valid high, enable high, FIFO not full: push the word.
  - evt_valid high, enable high, FIFO full: discard the event and increment dropped_count.
  - enable low: discard silently; no counter changes.
- **FSM states:** IDLE, WR_LO, WR_HI.
  - IDLE → WR_LO when the FIFO is not empty and enable is high. Pop the FIFO into a holding register. Drive avm_write=1, avm_address=BASE_ADDR+(wr_ptr<<1), avm_writedata=hold[15:0].
  - WR_LO → WR_HI on a cycle with avm_write=1 and avm_waitrequest=0. Increment wr_ptr. Drive address for the new wr_ptr and writedata=hold[31:16].
  - WR_HI → IDLE on acceptance. Increment wr_ptr and event_count. Deassert avm_write.
  - While avm_waitrequest=1, address, data and write are held stable.
- **Pointer:** wr_ptr is PTR_W bits and wraps naturally from 2^PTR_W−1 to 0; the wrap sets wrapped. wr_ptr is even in IDLE, so an event never straddles the wrap.
- **Enable deasserted mid-event:** the current event completes both words; the FSM then stays in IDLE. FIFO contents remain and drain when enable returns.
- **Simultaneous push and pop, FIFO full:** the pop happens, but the push is still rejected because the full check uses the pre-pop state. The event is counted as dropped.
- **Reset (any time, including mid-burst):**
  - Clears FIFO, FSM (→ IDLE), wr_ptr, counters and wrapped.
  - avm_write goes low asynchronously.
  - A half-written event is abandoned.
- **Output reset values:** avm_address=0, avm_write=0, avm_writedata=0, avm_byteenable=0, wr_ptr=0, event_count=0, dropped_count=0, wrapped=0.

## Timing
- All outputs are registered.
- FIFO push is visible as not-empty the cycle after evt_valid.
- evt_valid → first avm_write high: 2 cycles (push, then IDLE pop).
- Zero waitrequest: 3 cycles per event (IDLE, WR_LO, WR_HI). Sustained throughput is 1 event / 3 clocks.
- Each waitrequest cycle adds 1 cycle.
- event_count and wr_ptr update the cycle after the final write is accepted.

## Structure
- Shared package `dvs_pkg`:
  - event word type (32-bit packed struct: pol, ts, y, x);
  - FSM state enum;
  - word-format field widths.
- One sub-module: `dvs_event_fifo`, a synchronous FIFO, width 32, depth 2^FIFO_AW, with full and empty flags, and the same clock and asynchronous reset.

## Test plan
- **Single event:** x=8'h12, y=8'h34, pol=1, ts=15'h0005, no waitrequest.
  - Write 1: addr=BASE_ADDR, data=16'h3412.
  - Write 2: addr=BASE_ADDR+2, data=16'h8005.
  - Then event_count=1, wr_ptr=2.
- **Waitrequest stall:** hold waitrequest high 4 cycles on the WR_LO word. Address and data stay stable; the event completes in 7 cycles.
- **Overflow:** FIFO_AW=2, waitrequest held high, 7 back-to-back events. Expect 1 in the holding register, 4 in the FIFO, dropped_count=2. Release waitrequest: 5 events are written.
- **Wrap:** PTR_W=3, 5 events. The 5th event is written at BASE_ADDR+0/+2, wr_ptr=2, wrapped=1, event_count=5.
- **Enable low mid-event:** the current event completes. Events presented while enable is low are neither stored nor counted as dropped.
- **Reset during WR_HI:** avm_write drops with no clock edge. After release, all outputs are 0 and the next event is written at BASE_ADDR.
